nibble_serial_add_ctrl: RTL
===========================

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 The block SHALL have one parameter: NIBBLES, default 4, number of 4-bit nibbles per operand (operand width W = 4*NIBBLES, NIBBLES >= 1).
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Port clk, input, 1, rising-edge clock for all state.
REQ-004 Port rst_n, input, 1, synchronous active-low reset.
REQ-005 Port start, input, 1, request to begin one W-bit addition; sampled only in IDLE.
REQ-006 Port a, input, W, operand A; captured on the accepted start edge.
REQ-007 Port b, input, W, operand B; captured on the accepted start edge.
REQ-008 Port cin, input, 1, carry-in to nibble 0; captured on the accepted start edge.
REQ-009 Port busy, output, 1, high whenever state is not IDLE.
REQ-010 Port done, output, 1, single-cycle pulse marking sum/cout valid.
REQ-011 Port sum, output, W, registered result; holds value until the next completion.
REQ-012 Port cout, output, 1, registered carry-out of the top nibble; holds like sum.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 In IDLE with start=1 at a rising edge, a/b/cin SHALL be loaded into internal operand and carry registers, nibble index cleared to 0, state -> RUN.
REQ-015 In IDLE with start=0, the state SHALL remain IDLE and all outputs SHALL hold.
REQ-016 Each RUN edge SHALL present nibble[idx] of A and B plus the carry register to one 4-bit ripple adder, write the 4-bit sum into accumulator nibble[idx], load the carry register from the adder's carry-out, and increment idx.
REQ-017 On the RUN edge where idx = NIBBLES-1, sum SHALL load the completed accumulator, cout SHALL load that edge's adder carry-out, and state -> DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return the state to IDLE.
REQ-019 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+NIBBLES, and busy SHALL be high from edge k through edge k+NIBBLES+1.
REQ-020 While RUN or DONE, start SHALL be ignored, including a start coincident with the DONE cycle; no queuing.
REQ-021 Operands captured at start SHALL be used; a/b/cin changes during RUN SHALL NOT affect the result.
REQ-022 The sum and cout outputs SHALL change only on the edge entering DONE, never with partial results.
REQ-023 Arithmetic: {cout,sum} SHALL equal a + b + cin modulo 2^(W+1) for all inputs.
REQ-024 idx SHALL be ceil(log2(NIBBLES)) bits wide (minimum 1), and SHALL never exceed NIBBLES-1.

Reset
REQ-025 When rst_n=0 at a rising edge, the state SHALL go to IDLE; busy, done, sum, cout, idx, carry register, operand registers and accumulator SHALL go to 0.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no done pulse, and the held sum/cout SHALL be cleared to 0.
REQ-027 Reset SHALL take priority over start at the same edge.

Structure
REQ-028 The state encoding (IDLE/RUN/DONE) and the nibble width constant 4 SHALL be defined in a shared package, adder_ctrl_pkg.
REQ-029 The 4-bit add SHALL be one instance of the team's existing ripple_carry_adder sub-module, with per-bit ports wired from the selected nibbles; the block SHALL contain no other adder.

Verification
REQ-030 NIBBLES=4, a=0x1234, b=0x4321, cin=0, start at edge k -> sum=0x5555, cout=0, done high only in the cycle after edge k+4.
REQ-031 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all four nibbles); a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
REQ-032 Start with a=0x00FF, b=0x0001; pulse start again at edge k+2 with a=0x1111 -> the second start is ignored, result is sum=0x0100, cout=0, and exactly one done pulse occurs.
REQ-033 Start a=0x8000, b=0x8000; change a/b at edge k+1 -> sum=0x0000, cout=1 (captured operands used).
REQ-034 After a completed add (sum=0x5555), start a new add and assert rst_n=0 at edge k+2 -> no done pulse, then busy=0, sum=0x0000, cout=0; next start completes normally.
REQ-035 NIBBLES=2, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, done in the cycle after edge k+2.

Source files
------------

// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: FSM encoding and nibble width.
package adder_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that indexes n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder with per-bit ports.
module ripple_carry_adder (
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic cin,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic cout
);

  logic c1, c2, c3;

  always_comb begin
    s0   = a0 ^ b0 ^ cin;
    c1   = (a0 & b0) | (a0 & cin) | (b0 & cin);
    s1   = a1 ^ b1 ^ c1;
    c2   = (a1 & b1) | (a1 & c1) | (b1 & c1);
    s2   = a2 ^ b2 ^ c2;
    c3   = (a2 & b2) | (a2 & c2) | (b2 & c2);
    s3   = a3 ^ b3 ^ c3;
    cout = (a3 & b3) | (a3 & c3) | (b3 & c3);
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Serial W-bit adder: one nibble per clock through a single 4-bit ripple adder.
module nibble_serial_add_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          cin,
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          cout
);

  localparam int unsigned W  = NIBBLE_W * NIBBLES;
  localparam int unsigned IW = idx_width(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t state, state_next;

  logic [W-1:0]        a_reg, b_reg, acc, acc_next;
  logic [IW-1:0]       idx;
  logic                carry;
  logic [NIBBLE_W-1:0] a_nib, b_nib, add_sum;
  logic                add_cout;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Operand nibble mux and accumulator merge share one decode of idx.
  always_comb begin
    a_nib    = '0;
    b_nib    = '0;
    acc_next = acc;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_reg[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_reg[i*NIBBLE_W +: NIBBLE_W];
        acc_next[i*NIBBLE_W +: NIBBLE_W] = add_sum;
      end
    end
  end

  ripple_carry_adder u_rca (
    .a0   (a_nib[0]),
    .a1   (a_nib[1]),
    .a2   (a_nib[2]),
    .a3   (a_nib[3]),
    .b0   (b_nib[0]),
    .b1   (b_nib[1]),
    .b2   (b_nib[2]),
    .b3   (b_nib[3]),
    .cin  (carry),
    .s0   (add_sum[0]),
    .s1   (add_sum[1]),
    .s2   (add_sum[2]),
    .s3   (add_sum[3]),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= add_cout;
          // Final nibble: publish the merged accumulator so sum never shows partials.
          if (idx == LAST_IDX) begin
            sum  <= acc_next;
            cout <= add_cout;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
